// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, in-order word fetch over req/resp, 2-entry output buffer to IF/ID.
// Latency: request accepted in cycle N, response in N+k, instruction visible at out_valid in N+k+1.
// Backpressure: stall holds the buffer head; new requests stop once outstanding+buffered reaches 2.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  output logic        out_valid,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic [31:0] pcPlus4_out,
  output logic        err_out
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } entry_t;

  // Control state
  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] fetch_pc;
  logic [1:0]  outstanding;
  logic [1:0]  outstanding_nxt;
  logic [1:0]  drop_cnt;

  // Tag FIFO: PC of every accepted request, popped by every response (kept or dropped),
  // so its occupancy always equals outstanding.
  logic [31:0] tag_mem [2];
  logic        tag_wp;
  logic        tag_rp;

  // Output FIFO feeding IF/ID
  entry_t      fifo_mem [2];
  logic        fifo_wp;
  logic        fifo_rp;
  logic [1:0]  fifo_count;
  entry_t      head;
  entry_t      push_dat;

  // Per-cycle events
  logic        misaligned;
  logic        in_run;
  logic        pop;
  logic [2:0]  credit;
  logic        room;
  logic        accept;
  logic        rsp;
  logic        rsp_push;
  logic        rsp_drop;
  logic        mis_push;
  logic        push;

  assign misaligned = (fetch_pc[1:0] != 2'b00);
  assign in_run     = (state == RUN);
  assign out_valid  = (fifo_count != 2'd0);
  assign pop        = out_valid & ~stall;

  // A pop this cycle frees a slot, so a new request may issue alongside it; this is
  // what sustains one instruction per cycle with single-cycle memory.
  assign credit   = {1'b0, outstanding} + {1'b0, fifo_count} - {2'b00, pop};
  assign room     = (credit < 3'd2);

  assign imem_req  = in_run & ~flush & ~misaligned & room;
  assign imem_addr = imem_req ? fetch_pc : 32'h0000_0000;
  assign accept    = imem_req & imem_ready;

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign rsp      = imem_rvalid & (outstanding != 2'd0);
  assign rsp_push = rsp & ~flush & (drop_cnt == 2'd0);
  assign rsp_drop = rsp & (drop_cnt != 2'd0);

  // Misaligned PC: no memory access, a faulting NOP goes straight into the buffer.
  // Only reachable with nothing outstanding, but never collide with a response push.
  assign mis_push = in_run & ~flush & misaligned & room & ~rsp_push;
  assign push     = rsp_push | mis_push;

  assign outstanding_nxt = outstanding + {1'b0, accept} - {1'b0, rsp};

  // Select the entry to buffer: faulting NOP for misalignment, else tagged response
  always_comb begin
    push_dat = '0;
    if (mis_push) begin
      push_dat.pc    = fetch_pc;
      push_dat.instr = NOP;
      push_dat.err   = 1'b1;
    end else begin
      push_dat.pc    = tag_mem[tag_rp];
      push_dat.instr = imem_err ? NOP : imem_rdata;
      push_dat.err   = imem_err;
    end
  end

  // Next-state logic; flush overrides every state
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = (outstanding_nxt != 2'd0) ? DRAIN : RUN;
    end else begin
      case (state)
        BOOT:    state_nxt = RUN;
        RUN:     if (mis_push) state_nxt = FAULT;
        DRAIN:   if (drop_cnt == 2'd0) state_nxt = RUN;
        FAULT:   state_nxt = FAULT;
        default: state_nxt = BOOT;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Fetch PC: redirect on flush, otherwise advance on each accepted request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
    end else if (flush) begin
      fetch_pc <= redirect_pc;
    end else if (accept) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // Outstanding request counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= 2'd0;
    end else begin
      outstanding <= outstanding_nxt;
    end
  end

  // Drop counter: on flush every still-outstanding response becomes a drop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= 2'd0;
    end else if (flush) begin
      drop_cnt <= outstanding_nxt;
    end else if (rsp_drop) begin
      drop_cnt <= drop_cnt - 2'd1;
    end
  end

  // Tag FIFO: survives flush so late responses still line up with their PCs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        tag_mem[i] <= 32'h0000_0000;
      end
      tag_wp <= 1'b0;
      tag_rp <= 1'b0;
    end else begin
      if (accept) begin
        tag_mem[tag_wp] <= fetch_pc;
        tag_wp          <= ~tag_wp;
      end
      if (rsp) begin
        tag_rp <= ~tag_rp;
      end
    end
  end

  // Output FIFO: emptied on flush, else push/pop with simultaneous pop+push allowed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_mem[i] <= '0;
      end
      fifo_wp    <= 1'b0;
      fifo_rp    <= 1'b0;
      fifo_count <= 2'd0;
    end else if (flush) begin
      fifo_wp    <= 1'b0;
      fifo_rp    <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[fifo_wp] <= push_dat;
        fifo_wp           <= ~fifo_wp;
      end
      if (pop) begin
        fifo_rp <= ~fifo_rp;
      end
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Data outputs read zero whenever the buffer is empty
  assign head        = fifo_mem[fifo_rp];
  assign pc_out      = out_valid ? head.pc : 32'h0000_0000;
  assign instr_out   = out_valid ? head.instr : 32'h0000_0000;
  assign pcPlus4_out = out_valid ? (head.pc + 32'd4) : 32'h0000_0000;
  assign err_out     = out_valid & head.err;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order fixed-latency memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        out_valid;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic [31:0] pcPlus4_out;
  logic        err_out;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .imem_err    (imem_err),
    .out_valid   (out_valid),
    .pc_out      (pc_out),
    .instr_out   (instr_out),
    .pcPlus4_out (pcPlus4_out),
    .err_out     (err_out)
  );

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] err_addr = 32'h0000_0108;
  logic [31:0] pend_addr [$];
  int          pend_due [$];
  logic [31:0] exp_pc;
  int          n;
  int          reqs;
  logic        saw_req;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: record acceptance mid-cycle, then present any due response after the edge
  task automatic tick();
    @(negedge clk);
    if (rst && imem_req && imem_ready) begin
      pend_addr.push_back(imem_addr);
      pend_due.push_back(cyc + lat);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (imem_rvalid && pend_addr.size() > 0) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    imem_err    = 1'b0;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_addr[0]);
      imem_err    = (pend_addr[0] == err_addr);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_req"}, imem_req, 1'b0);
    chk32({tag, "_addr"}, imem_addr, 32'h0);
    chk1({tag, "_valid"}, out_valid, 1'b0);
    chk32({tag, "_pc"}, pc_out, 32'h0);
    chk32({tag, "_instr"}, instr_out, 32'h0);
    chk32({tag, "_pc4"}, pcPlus4_out, 32'h0);
    chk1({tag, "_err"}, err_out, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = 32'h0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0; imem_err = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");

    // Boot: cycle 0 idle, consecutive fetches from cycle 1
    rst = 1'b1; cyc = 0;
    #1;
    chk1("boot_no_req", imem_req, 1'b0);
    tick();
    chk1("c1_req", imem_req, 1'b1);
    chk32("c1_addr", imem_addr, 32'h100);
    tick();
    chk32("c2_addr", imem_addr, 32'h104);
    chk1("c2_valid", out_valid, 1'b0);
    tick();
    chk32("c3_addr", imem_addr, 32'h108);
    chk1("c3_valid", out_valid, 1'b1);
    chk32("c3_pc", pc_out, 32'h100);
    chk32("c3_pc4", pcPlus4_out, 32'h104);
    chk32("c3_instr", instr_out, 32'hC0DE_0100);
    chk1("c3_err", err_out, 1'b0);
    tick();
    chk32("c4_pc", pc_out, 32'h104);

    // Memory fault on 0x108
    tick();
    chk1("fault_valid", out_valid, 1'b1);
    chk32("fault_pc", pc_out, 32'h108);
    chk1("fault_err", err_out, 1'b1);
    chk32("fault_instr", instr_out, 32'h0000_0013);
    tick();
    chk32("after_fault_pc", pc_out, 32'h10C);
    chk1("after_fault_err", err_out, 1'b0);
    chk32("after_fault_instr", instr_out, 32'hC0DE_010C);

    // Stall for 5 cycles (7..11)
    tick();
    stall = 1'b1;
    #1;
    chk32("stall_head", pc_out, 32'h110);
    reqs = 0;
    for (int i = 0; i < 4; i++) begin
      if (imem_req && imem_ready) reqs++;
      tick();
      chk1("stall_valid", out_valid, 1'b1);
      chk32("stall_held_pc", pc_out, 32'h110);
      chk32("stall_held_instr", instr_out, 32'hC0DE_0110);
    end
    if (imem_req && imem_ready) reqs++;
    chk1("stall_req_bound", (reqs <= 2), 1'b1);
    stall = 1'b0;
    #1;
    exp_pc = 32'h110;
    n = 0;
    for (int i = 0; i < 16 && n < 6; i++) begin
      if (out_valid) begin
        chk32("stream_pc", pc_out, exp_pc);
        exp_pc = exp_pc + 32'd4;
        n++;
      end
      tick();
    end
    chk32("stream_count", 32'(n), 32'd6);

    // Flush with two responses in flight, latency 3
    lat = 3;
    for (int i = 0; i < 30 && !(pend_addr.size() == 2 && !imem_rvalid); i++) tick();
    chk1("flush_setup", (pend_addr.size() == 2 && !imem_rvalid), 1'b1);
    flush = 1'b1; redirect_pc = 32'h400;
    #1;
    chk1("flush_gates_req", imem_req, 1'b0);
    tick();
    flush = 1'b0;
    #1;
    chk1("flush_valid_low", out_valid, 1'b0);
    chk1("drain_no_req", imem_req, 1'b0);
    for (int i = 0; i < 20 && !imem_req; i++) tick();
    chk32("drain_first_addr", imem_addr, 32'h400);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    chk1("drain_first_valid", out_valid, 1'b1);
    chk32("drain_first_pc", pc_out, 32'h400);

    // Misaligned redirect, issued together with stall (flush wins)
    lat = 1;
    repeat (3) tick();
    flush = 1'b1; stall = 1'b1; redirect_pc = 32'h202;
    tick();
    flush = 1'b0; stall = 1'b0;
    #1;
    chk1("mis_flush_valid_low", out_valid, 1'b0);
    saw_req = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) begin
      if (imem_req) saw_req = 1'b1;
      tick();
    end
    chk1("mis_no_req", saw_req | imem_req, 1'b0);
    chk1("mis_valid", out_valid, 1'b1);
    chk1("mis_err", err_out, 1'b1);
    chk32("mis_pc", pc_out, 32'h202);
    chk32("mis_instr", instr_out, 32'h0000_0013);
    chk32("mis_pc4", pcPlus4_out, 32'h206);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("fault_state_no_req", imem_req, 1'b0);
      chk1("fault_state_no_valid", out_valid, 1'b0);
    end
    flush = 1'b1; redirect_pc = 32'h300;
    tick();
    flush = 1'b0;
    #1;
    chk1("resume_req", imem_req, 1'b1);
    chk32("resume_addr", imem_addr, 32'h300);

    // Wrap at 2^32
    repeat (3) tick();
    flush = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0;
    #1;
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    chk32("wrap_pc", pc_out, 32'hFFFF_FFFC);
    chk32("wrap_pc4", pcPlus4_out, 32'h0);
    tick();
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    chk32("wrap_next_pc", pc_out, 32'h0);
    chk32("wrap_next_instr", instr_out, 32'hC0DE_0000);

    // Mid-stream asynchronous reset
    tick();
    rst = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    imem_rvalid = 1'b0; imem_rdata = 32'h0; imem_err = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; cyc = 0;
    #1;
    chk1("rerst_c0_req", imem_req, 1'b0);
    tick();
    chk1("rerst_c1_req", imem_req, 1'b1);
    chk32("rerst_c1_addr", imem_addr, 32'h100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
